// File: rtl/pifo_reg_bank_if.sv
// Slot-bank bus between the PIFO register bank, its producer/consumer and the min tree.
// Optional error-flag output appears when PIFO_REG_ERR_EN is defined.
interface pifo_reg_bank_if #(
    parameter int unsigned REG_WIDTH  = 4,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                            ins_valid;
    logic [DATA_WIDTH-1:0]           ins_rank;
    logic                            ins_ready;
    logic                            deq_req;
    logic [IDX_WIDTH-1:0]            deq_idx;
    logic                            deq_valid;
    logic [DATA_WIDTH-1:0]           deq_rank;
    logic [REG_WIDTH*DATA_WIDTH-1:0] data_out;
    logic [REG_WIDTH*IDX_WIDTH-1:0]  idx_out;
    logic [REG_WIDTH-1:0]            vld_out;
    logic [IDX_WIDTH:0]              count;
    logic                            full;
    logic                            empty;
`ifdef PIFO_REG_ERR_EN
    logic [1:0]                      err_flags;
`endif

    modport master (
`ifdef PIFO_REG_ERR_EN
        input  err_flags,
`endif
        output ins_valid, ins_rank, deq_req, deq_idx,
        input  ins_ready, deq_valid, deq_rank, data_out, idx_out, vld_out,
               count, full, empty
    );

    modport slave (
`ifdef PIFO_REG_ERR_EN
        output err_flags,
`endif
        input  ins_valid, ins_rank, deq_req, deq_idx,
        output ins_ready, deq_valid, deq_rank, data_out, idx_out, vld_out,
               count, full, empty
    );
endinterface

// File: rtl/pifo_reg_bank.sv
// PIFO slot register bank: inserts fill the lowest free slot, removals free a slot chosen by the min tree.
// Define PIFO_REG_ERR_EN to add sticky err_flags (bit0 insert-while-full, bit1 remove-of-invalid-slot).
module pifo_reg_bank #(
    parameter int unsigned REG_WIDTH  = 4,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           axis_aclk,
    input  logic           axis_resetn,
    pifo_reg_bank_if.slave bus
);
    localparam int unsigned CNT_WIDTH = IDX_WIDTH + 1;

    logic [REG_WIDTH-1:0]            r_vld;
    logic [DATA_WIDTH-1:0]           r_rank [REG_WIDTH];
    logic [CNT_WIDTH-1:0]            r_count;
    logic                            r_full;
    logic                            r_empty;
    logic                            r_ins_ready;
    logic                            r_deq_valid;
    logic [DATA_WIDTH-1:0]           r_deq_rank;

    logic                            w_ins_fire;
    logic                            w_deq_fire;
    logic [IDX_WIDTH-1:0]            w_free_idx;
    logic [CNT_WIDTH-1:0]            w_count_nxt;
    logic [REG_WIDTH*DATA_WIDTH-1:0] w_data_flat;
    logic [REG_WIDTH*IDX_WIDTH-1:0]  w_idx_flat;

    // Both fire conditions look only at pre-edge slot state, so an insert can never land in
    // the slot being freed on the same edge (that slot still reads valid here).
    assign w_ins_fire = bus.ins_valid & r_ins_ready;
    assign w_deq_fire = bus.deq_req & r_vld[bus.deq_idx];

    // Lowest-numbered free slot
    always_comb begin
        w_free_idx = '0;
        for (int i = REG_WIDTH - 1; i >= 0; i--) begin
            if (!r_vld[i]) w_free_idx = IDX_WIDTH'(i);
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_ins_fire && !w_deq_fire) begin
            w_count_nxt = r_count + CNT_WIDTH'(1);
        end else if (!w_ins_fire && w_deq_fire) begin
            w_count_nxt = r_count - CNT_WIDTH'(1);
        end
    end

    // Slot state; ranks of freed slots are left in place, only vld drops
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_vld <= '0;
            for (int i = 0; i < REG_WIDTH; i++) r_rank[i] <= '0;
        end else begin
            if (w_deq_fire) r_vld[bus.deq_idx] <= 1'b0;
            if (w_ins_fire) begin
                r_vld[w_free_idx]  <= 1'b1;
                r_rank[w_free_idx] <= bus.ins_rank;
            end
        end
    end

    // Occupancy and status flags, registered from the next count
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_ins_ready <= 1'b1;
        end else begin
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CNT_WIDTH'(REG_WIDTH));
            r_empty     <= (w_count_nxt == CNT_WIDTH'(0));
            r_ins_ready <= (w_count_nxt != CNT_WIDTH'(REG_WIDTH));
        end
    end

    // Removal result: one-cycle pulse, rank held between pulses
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_deq_valid <= 1'b0;
            r_deq_rank  <= '0;
        end else begin
            r_deq_valid <= w_deq_fire;
            if (w_deq_fire) r_deq_rank <= r_rank[bus.deq_idx];
        end
    end

    always_comb begin
        w_data_flat = '0;
        w_idx_flat  = '0;
        for (int k = 0; k < REG_WIDTH; k++) begin
            w_data_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_rank[k];
            w_idx_flat[k*IDX_WIDTH +: IDX_WIDTH]    = IDX_WIDTH'(k);
        end
    end

    assign bus.data_out  = w_data_flat;
    assign bus.idx_out   = w_idx_flat;
    assign bus.vld_out   = r_vld;
    assign bus.count     = r_count;
    assign bus.full      = r_full;
    assign bus.empty     = r_empty;
    assign bus.ins_ready = r_ins_ready;
    assign bus.deq_valid = r_deq_valid;
    assign bus.deq_rank  = r_deq_rank;

`ifdef PIFO_REG_ERR_EN
    logic [1:0] r_err;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_err <= '0;
        end else begin
            if (bus.ins_valid && r_full)               r_err[0] <= 1'b1;
            if (bus.deq_req && !r_vld[bus.deq_idx])    r_err[1] <= 1'b1;
        end
    end

    assign bus.err_flags = r_err;
`endif
endmodule

// File: tb/tb_pifo_reg_bank.sv
// Self-checking bench for pifo_reg_bank: directed fill/remove/reuse/reset cases plus a
// min-tree closed loop; removed ranks are scoreboarded against a reference slot model.
module tb_pifo_reg_bank;
    localparam int unsigned RW = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned DW = 8;

    logic clk;
    logic rst_n;

    pifo_reg_bank_if #(.REG_WIDTH(RW), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

    pifo_reg_bank #(.REG_WIDTH(RW), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .axis_aclk   (clk),
        .axis_resetn (rst_n),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic [DW-1:0] sb [$];
    logic          m_vld  [RW];
    logic [DW-1:0] m_rank [RW];
    logic [DW-1:0] sb_exp;
    logic [DW-1:0] exp_seq [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RW; i++) begin
            m_vld[i]  = 1'b0;
            m_rank[i] = '0;
        end
        sb.delete();
    endtask

    // Drive one cycle of stimulus from a negedge; the reference model updates in step
    task automatic step(input logic iv, input logic [DW-1:0] ir, input logic dr, input logic [IW-1:0] di);
        int cnt;
        int free;
        cnt  = 0;
        free = -1;
        for (int i = 0; i < RW; i++) begin
            if (m_vld[i]) cnt++;
            else if (free < 0) free = i;
        end
        bus.ins_valid = iv;
        bus.ins_rank  = ir;
        bus.deq_req   = dr;
        bus.deq_idx   = di;
        if (dr && m_vld[di]) begin
            sb.push_back(m_rank[di]);
            m_vld[di] = 1'b0;
        end
        if (iv && cnt < RW) begin
            m_vld[free]  = 1'b1;
            m_rank[free] = ir;
        end
        @(negedge clk);
        bus.ins_valid = 1'b0;
        bus.deq_req   = 1'b0;
    endtask

    // Every deq_valid pulse must match the oldest outstanding expected rank
    always @(negedge clk) begin
        if (rst_n && bus.deq_valid) begin
            if (sb.size() == 0) begin
                check("deq_unexpected", 32'(bus.deq_valid), 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                check("sb_deq_rank", 32'(bus.deq_rank), 32'(sb_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        exp_seq[0] = 8'd3; exp_seq[1] = 8'd5; exp_seq[2] = 8'd7; exp_seq[3] = 8'd9;
        rst_n         = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins_rank  = '0;
        bus.deq_req   = 1'b0;
        bus.deq_idx   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_vld",       32'(bus.vld_out),   32'h0);
        check("rst_count",     32'(bus.count),     32'd0);
        check("rst_empty",     32'(bus.empty),     32'd1);
        check("rst_full",      32'(bus.full),      32'd0);
        check("rst_ins_ready", 32'(bus.ins_ready), 32'd1);
        check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        check("rst_deq_rank",  32'(bus.deq_rank),  32'd0);
        check("rst_idx_out",   32'(bus.idx_out),   32'b11_10_01_00);
        rst_n = 1'b1;

        // Fill
        step(1'b1, 8'd9, 1'b0, 2'd0);
        check("fill_count1", 32'(bus.count), 32'd1);
        check("fill_empty1", 32'(bus.empty), 32'd0);
        step(1'b1, 8'd3, 1'b0, 2'd0);
        step(1'b1, 8'd7, 1'b0, 2'd0);
        step(1'b1, 8'd5, 1'b0, 2'd0);
        check("fill_data",      32'(bus.data_out),  32'h05070309);
        check("fill_vld",       32'(bus.vld_out),   32'hf);
        check("fill_full",      32'(bus.full),      32'd1);
        check("fill_ins_ready", 32'(bus.ins_ready), 32'd0);
        check("fill_count4",    32'(bus.count),     32'd4);
        step(1'b1, 8'd8, 1'b0, 2'd0);
        check("fifth_data",  32'(bus.data_out), 32'h05070309);
        check("fifth_count", 32'(bus.count),    32'd4);

        // Remove slot 1
        step(1'b0, 8'd0, 1'b1, 2'd1);
        check("rm_deq_valid", 32'(bus.deq_valid), 32'd1);
        check("rm_deq_rank",  32'(bus.deq_rank),  32'd3);
        check("rm_vld",       32'(bus.vld_out),   32'b1101);
        check("rm_count",     32'(bus.count),     32'd3);
        step(1'b0, 8'd0, 1'b0, 2'd0);
        check("hold_deq_valid", 32'(bus.deq_valid), 32'd0);
        check("hold_deq_rank",  32'(bus.deq_rank),  32'd3);

        // Simultaneous insert + remove of slot 0
        step(1'b1, 8'd1, 1'b1, 2'd0);
        check("sim_data",     32'(bus.data_out), 32'h05070109);
        check("sim_vld",      32'(bus.vld_out),  32'b1110);
        check("sim_deq_rank", 32'(bus.deq_rank), 32'd9);
        check("sim_count",    32'(bus.count),    32'd3);

        // Full: removal does not open the insert in the same cycle
        step(1'b1, 8'd2, 1'b0, 2'd0);
        check("refill_data", 32'(bus.data_out), 32'h05070102);
        check("refill_full", 32'(bus.full),     32'd1);
        step(1'b1, 8'd4, 1'b1, 2'd2);
        check("fullrm_vld",   32'(bus.vld_out),   32'b1011);
        check("fullrm_count", 32'(bus.count),     32'd3);
        check("fullrm_data",  32'(bus.data_out),  32'h05070102);
        check("fullrm_rank",  32'(bus.deq_rank),  32'd7);
        check("fullrm_ready", 32'(bus.ins_ready), 32'd1);
        step(1'b1, 8'd4, 1'b0, 2'd0);
        check("reins_data",  32'(bus.data_out), 32'h05040102);
        check("reins_count", 32'(bus.count),    32'd4);

        // Reset mid-operation
        bus.ins_valid = 1'b1;
        bus.ins_rank  = 8'd6;
        bus.deq_req   = 1'b1;
        bus.deq_idx   = 2'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_vld",       32'(bus.vld_out),   32'h0);
        check("mrst_count",     32'(bus.count),     32'd0);
        check("mrst_empty",     32'(bus.empty),     32'd1);
        check("mrst_ins_ready", 32'(bus.ins_ready), 32'd1);
        check("mrst_deq_valid", 32'(bus.deq_valid), 32'd0);
        check("mrst_data",      32'(bus.data_out),  32'h0);
        bus.ins_valid = 1'b0;
        bus.deq_req   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0, 2'd0);
        check("post_rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        check("post_rst_count",     32'(bus.count),     32'd0);

        // Bad remove on empty bank
        step(1'b0, 8'd0, 1'b1, 2'd2);
        check("bad_deq_valid", 32'(bus.deq_valid), 32'd0);
        check("bad_count",     32'(bus.count),     32'd0);
        check("bad_empty",     32'(bus.empty),     32'd1);
`ifdef PIFO_REG_ERR_EN
        check("bad_err_flags", 32'(bus.err_flags), 32'b10);
`endif

        // Closed loop with a reference min tree (lowest index wins ties)
        step(1'b1, 8'd9, 1'b0, 2'd0);
        step(1'b1, 8'd3, 1'b0, 2'd0);
        step(1'b1, 8'd7, 1'b0, 2'd0);
        step(1'b1, 8'd5, 1'b0, 2'd0);
        for (int n = 0; n < 4; n++) begin
            w = -1;
            for (int i = 0; i < RW; i++) begin
                if (m_vld[i] && (w < 0 || m_rank[i] < m_rank[w])) w = i;
            end
            step(1'b0, 8'd0, 1'b1, IW'(w));
            check("loop_deq_valid", 32'(bus.deq_valid), 32'd1);
            check("loop_deq_rank",  32'(bus.deq_rank),  32'(exp_seq[n]));
        end
        check("loop_empty", 32'(bus.empty), 32'd1);
        check("loop_count", 32'(bus.count), 32'd0);

        step(1'b0, 8'd0, 1'b0, 2'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/pifo_reg_bank.md
PIFO_REG_BANK -- requirements
Module: pifo_reg_bank

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 4, number of storage slots (power of two, >=2).
REQ-002 SHALL have parameter IDX_WIDTH, default 2, slot index width, equal to log2(REG_WIDTH).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, rank width (unsigned).
REQ-004 SHALL have port axis_aclk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port axis_resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ins_valid  input  1  insert request.
REQ-007 SHALL have port ins_rank  input  DATA_WIDTH  rank to insert.
REQ-008 SHALL have port ins_ready  output  1  slot free; insert accepted when ins_valid&ins_ready.
REQ-009 SHALL have port deq_req  input  1  remove request.
REQ-010 SHALL have port deq_idx  input  IDX_WIDTH  slot to remove (winning index from min tree).
REQ-011 SHALL have port deq_valid  output  1  one-cycle pulse, removed entry on deq_rank.
REQ-012 SHALL have port deq_rank  output  DATA_WIDTH  rank of removed slot.
REQ-013 SHALL have ports data_out (REG_WIDTH*DATA_WIDTH), idx_out (REG_WIDTH*IDX_WIDTH), vld_out (REG_WIDTH), all outputs, flattened slot state to the min tree, slot k in field k.
REQ-014 SHALL have ports count (IDX_WIDTH+1), full (1), empty (1), all outputs.

Function
REQ-015 SHALL drive idx_out field k with constant k, data_out/vld_out directly from slot registers (no combinational path from inputs).
REQ-016 SHALL drive ins_ready = ~full, full = (count==REG_WIDTH), empty = (count==0), all derived from registered state.
REQ-017 SHALL write an accepted insert into the lowest-numbered slot with vld=0, as evaluated on state before the edge; slot visible on vld_out one cycle after acceptance.
REQ-018 SHALL, on deq_req with slot deq_idx valid, clear that slot's vld and assert deq_valid with its rank on the following cycle (latency 1).
REQ-019 SHALL ignore deq_req addressing an invalid slot: no state change, deq_valid stays 0.
REQ-020 SHALL hold deq_rank at its last value when deq_valid=0.
REQ-021 SHALL accept simultaneous insert and valid remove in one cycle; count unchanged; insert never targets the slot freed in that same cycle.
REQ-022 SHALL reject inserts while full (ins_ready=0); removal the same cycle does not make the insert acceptable until the next cycle.
REQ-023 SHALL update count by +1 on accepted insert, -1 on valid remove, 0 on both or neither; count never wraps.
REQ-024 SHALL leave rank contents of freed slots unchanged (only vld cleared).

Reset
REQ-025 SHALL on axis_resetn=0 asynchronously clear all slot vld bits, slot ranks, deq_rank to 0, deq_valid=0, count=0 (full=0, empty=1, ins_ready=1).
REQ-026 SHALL discard any insert or remove in flight when reset asserts mid-operation; no deq_valid pulse after reset release without a new deq_req.

Configuration
REQ-027 SHALL, with macro PIFO_REG_ERR_EN defined, add output err_flags[1:0]: bit0 sticky on ins_valid while full, bit1 sticky on deq_req to invalid slot; cleared only by reset.
REQ-028 SHALL, without PIFO_REG_ERR_EN, omit err_flags port and associated logic; all other behaviour identical.

Verification
REQ-029 SHALL test reset: drive axis_resetn=0 mid-insert -> vld_out=0, count=0, empty=1, ins_ready=1 immediately.
REQ-030 SHALL test fill: insert ranks 9,3,7,5 on consecutive cycles -> slots 0..3 hold 9,3,7,5, vld_out=4'b1111, full=1, ins_ready=0, fifth insert ignored.
REQ-031 SHALL test remove: from full state, deq_req deq_idx=1 -> next cycle deq_valid=1, deq_rank=3, vld_out=4'b1101, count=3.
REQ-032 SHALL test reuse/simultaneous: slots 0,2,3 valid, insert rank 1 with deq_req deq_idx=0 same cycle -> slot 1 gets 1, slot 0 cleared, deq_rank=9, count=3.
REQ-033 SHALL test bad remove: empty bank, deq_req deq_idx=2 -> deq_valid=0, count=0; with PIFO_REG_ERR_EN err_flags=2'b10.
REQ-034 SHALL test closed loop with min tree: insert 9,3,7,5, repeatedly dequeue min-tree winner -> deq_rank sequence 3,5,7,9, then empty=1.
